// File: rtl/boot_loader.sv
// boot_loader: assembles a little-endian byte stream into instruction words, writes them to
// instruction memory, then releases the core and times its run until HALT or budget expiry.
module boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CYCLES = 700
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOAD_START,
  input  logic [ADDR_WIDTH:0]   LOAD_LEN,
  input  logic                  RX_VALID,
  input  logic [7:0]            RX_DATA,
  output logic                  RX_READY,
  output logic                  IMEM_WE,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  output logic [DATA_WIDTH-1:0] IMEM_DATA,
  output logic                  CORE_RESET_N,
  input  logic                  HALT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  TIMEOUT,
  output logic [31:0]           CYCLE_COUNT
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BIDX_W-1:0]   LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [BIDX_W-1:0]   ONE_BYTE  = BIDX_W'(1);
  localparam logic [ADDR_WIDTH:0] MAX_LEN   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);
  localparam logic [31:0]         BUDGET    = 32'(MAX_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [31:0]           count_q, count_d;
  logic [31:0]           count_inc;
  logic                  last_word;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    last_word  = 1'b0;
    count_inc  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (LOAD_START) begin
          len_d      = LOAD_LEN[ADDR_WIDTH] ? MAX_LEN : LOAD_LEN;
          byte_idx_d = '0;
          word_cnt_d = '0;
          asm_d      = '0;
          count_d    = '0;
          timeout_d  = 1'b0;
          state_d    = (len_d == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        // RX_READY low inside LOAD marks the final write cycle
        if (!rx_ready_q) begin
          state_d = S_RUN;
        end else if (RX_VALID) begin
          for (int b = 0; b < BYTES; b++) begin
            if (byte_idx_q == BIDX_W'(b)) asm_d[8*b +: 8] = RX_DATA;
          end
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            data_d     = asm_d;
            word_cnt_d = word_cnt_q + ONE_WORD;
            last_word  = (word_cnt_d == len_q);
          end else begin
            byte_idx_d = byte_idx_q + ONE_BYTE;
          end
        end
      end
      S_RUN: begin
        count_d = count_inc;
        if (HALT) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if ((MAX_CYCLES != 0) && (count_inc == BUDGET)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d   = (state_d == S_LOAD) && !last_word;
    core_rst_n_d = (state_d == S_RUN);
    busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      asm_q        <= '0;
      rx_ready_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      asm_q        <= asm_d;
      rx_ready_q   <= rx_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end

  assign RX_READY     = rx_ready_q;
  assign IMEM_WE      = we_q;
  assign IMEM_ADDR    = addr_q;
  assign IMEM_DATA    = data_q;
  assign CORE_RESET_N = core_rst_n_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign TIMEOUT      = timeout_q;
  assign CYCLE_COUNT  = count_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: directed and randomized loads/runs checked against a word-queue
// and run-length model, plus a byte-wide instance for back-to-back writes.
module tb_boot_loader;
  localparam int MAXC = 700;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        ls, rxv, halt;
  logic [10:0] llen;
  logic [7:0]  rxd;
  logic        rdy, we, crn, busy, done, tmo;
  logic [9:0]  addr;
  logic [31:0] data, cnt;

  logic        b_ls, b_rxv, b_halt;
  logic [4:0]  b_len;
  logic [7:0]  b_rxd;
  logic        b_rdy, b_we, b_crn, b_busy, b_done, b_tmo;
  logic [3:0]  b_addr;
  logic [7:0]  b_data;
  logic [31:0] b_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] txq[$];
  wr_t  expq[$];
  wr_t  cmp_e;
  wr_t  lit_e;
  int   m_run;
  bit   prev_core, prev_halt, exit_exp;

  boot_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_CYCLES(MAXC)) dut (
    .CLK(clk), .RESET(rst), .LOAD_START(ls), .LOAD_LEN(llen), .RX_VALID(rxv), .RX_DATA(rxd),
    .RX_READY(rdy), .IMEM_WE(we), .IMEM_ADDR(addr), .IMEM_DATA(data), .CORE_RESET_N(crn),
    .HALT(halt), .BUSY(busy), .DONE(done), .TIMEOUT(tmo), .CYCLE_COUNT(cnt));

  boot_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .MAX_CYCLES(0)) dut8 (
    .CLK(clk), .RESET(rst), .LOAD_START(b_ls), .LOAD_LEN(b_len), .RX_VALID(b_rxv), .RX_DATA(b_rxd),
    .RX_READY(b_rdy), .IMEM_WE(b_we), .IMEM_ADDR(b_addr), .IMEM_DATA(b_data), .CORE_RESET_N(b_crn),
    .HALT(b_halt), .BUSY(b_busy), .DONE(b_done), .TIMEOUT(b_tmo), .CYCLE_COUNT(b_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int len);
    ls = 1'b1;
    llen = 11'(len);
    tick();
    ls = 1'b0;
  endtask

  task automatic rand_bytes(input int n);
    txq.delete();
    for (int i = 0; i < n; i++) txq.push_back(8'($urandom_range(1, 255)));
  endtask

  function automatic void queue_words(input int nw);
    wr_t e;
    for (int w = 0; w < nw; w++) begin
      e.a = 10'(w);
      e.d = {txq[4*w+3], txq[4*w+2], txq[4*w+1], txq[4*w]};
      expq.push_back(e);
    end
  endfunction

  task automatic send(input bit rnd);
    foreach (txq[i]) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          rxv = 1'b0;
          rxd = 8'($urandom);
          tick();
        end
      end
      rxv = 1'b1;
      rxd = txq[i];
      chk("rx_ready_in_load", rdy, 1);
      tick();
    end
    rxv = 1'b0;
  endtask

  task automatic wait_core();
    int n = 0;
    while (!crn && n < 50) begin
      tick();
      n++;
    end
    chk("core_release", crn, 1);
  endtask

  // Compare process: memory writes against the expected word queue, run length and exit cause
  initial begin
    prev_core = 1'b0;
    prev_halt = 1'b0;
    m_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_core = 1'b0;
        prev_halt = 1'b0;
      end else begin
        if (we) begin
          if (expq.size() == 0) begin
            chk("unexpected_imem_we", we, 0);
          end else begin
            cmp_e = expq.pop_front();
            chk("imem_addr", addr, cmp_e.a);
            chk("imem_data", data, cmp_e.d);
          end
        end
        if (prev_core) begin
          exit_exp = prev_halt || (m_run == MAXC);
          chk("run_exit", !crn, exit_exp);
          if (exit_exp) begin
            chk("done_at_exit", done, 1);
            chk("timeout_at_exit", tmo, !prev_halt);
            chk("count_at_exit", cnt, m_run);
          end
        end else if (crn) begin
          m_run = 0;
          chk("words_pending_at_run", expq.size(), 0);
        end
        if (crn) begin
          chk("run_count", cnt, m_run);
          chk("busy_in_run", busy, 1);
          m_run++;
        end
        chk("done_excludes_busy", done & busy, 0);
        prev_core = crn;
        prev_halt = halt;
      end
    end
  end

  initial begin
    rst = 1'b1; ls = 1'b0; llen = '0; rxv = 1'b0; rxd = '0; halt = 1'b0;
    b_ls = 1'b0; b_len = '0; b_rxv = 1'b0; b_rxd = '0; b_halt = 1'b0;
    repeat (2) tick();
    chk("rst_rx_ready", rdy, 0);
    chk("rst_core_reset_n", crn, 0);
    chk("rst_busy_done_tmo", {busy, done, tmo}, 0);
    chk("rst_count", cnt, 0);
    chk("rst_imem", {we, addr, data}, 0);
    rst = 1'b0;
    tick();

    // Directed two-word load, literal words
    txq = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    lit_e.a = 10'd0; lit_e.d = 32'h00500013; expq.push_back(lit_e);
    lit_e.a = 10'd1; lit_e.d = 32'h00100093; expq.push_back(lit_e);
    start(2);
    chk("load_busy", busy, 1);
    chk("load_core_held", crn, 0);
    send(1'b0);
    chk("t1_final_we", we, 1);
    chk("t1_final_addr", addr, 1);
    chk("t1_final_data", data, 32'h00100093);
    chk("t1_ready_dropped", rdy, 0);
    chk("t1_busy_write", busy, 1);
    chk("t1_core_still_held", crn, 0);
    tick();
    chk("t1_core_released", crn, 1);
    chk("t1_busy_run", busy, 1);
    chk("t1_count_start", cnt, 0);
    repeat (36) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_timeout", tmo, 0);
    chk("t1_count", cnt, 37);
    chk("t1_core_frozen", crn, 0);
    chk("t1_busy_off", busy, 0);
    repeat (3) tick();
    chk("t1_count_holds", cnt, 37);

    // Budget expiry
    rand_bytes(4); queue_words(1);
    start(1);
    chk("restart_clears_done", done, 0);
    send(1'b1);
    wait_core();
    begin
      int n = 0;
      while (!done && n < 800) begin tick(); n++; end
    end
    chk("to_done", done, 1);
    chk("to_timeout", tmo, 1);
    chk("to_count", cnt, 700);

    // HALT on the same edge as budget expiry
    rand_bytes(4); queue_words(1);
    start(1);
    chk("restart_clears_timeout", tmo, 0);
    send(1'b0);
    wait_core();
    repeat (699) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("tie_done", done, 1);
    chk("tie_timeout", tmo, 0);
    chk("tie_count", cnt, 700);

    // Randomized loads with gapped RX_VALID
    for (int it = 0; it < 4; it++) begin
      int len;
      len = (it == 0) ? 4 : $urandom_range(1, 5);
      rand_bytes(4 * len); queue_words(len);
      start(len);
      send(1'b1);
      wait_core();
      repeat ($urandom_range(0, 40)) tick();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("rand_done", done, 1);
      chk("rand_timeout", tmo, 0);
    end

    // Zero-length load, LOAD_START ignored during RUN
    start(0);
    chk("zero_core_released", crn, 1);
    chk("zero_busy", busy, 1);
    chk("zero_count", cnt, 0);
    chk("zero_ready", rdy, 0);
    repeat (5) tick();
    start(3);
    chk("ignored_start_core", crn, 1);
    chk("ignored_start_ready", rdy, 0);
    repeat (3) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("zero_run_count", cnt, 10);

    // Reset two bytes into word 1
    rand_bytes(6); queue_words(1);
    start(3);
    send(1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", rdy, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_imem", {we, addr, data}, 0);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_core", crn, 0);
    expq.delete();
    tick();
    rst = 1'b0;
    tick();
    rand_bytes(8); queue_words(2);
    start(2);
    send(1'b1);
    wait_core();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("reload_done", done, 1);

    // Byte-wide instance: back-to-back writes
    b_ls = 1'b1; b_len = 5'd2;
    tick();
    b_ls = 1'b0;
    chk("b_ready", b_rdy, 1);
    b_rxv = 1'b1; b_rxd = 8'hAA;
    tick();
    chk("b_w0", {b_we, b_addr, b_data}, {1'b1, 4'd0, 8'hAA});
    b_rxd = 8'hBB;
    tick();
    b_rxv = 1'b0;
    chk("b_w1", {b_we, b_addr, b_data}, {1'b1, 4'd1, 8'hBB});
    chk("b_ready_dropped", b_rdy, 0);
    tick();
    chk("b_core_released", {b_crn, b_we}, 2'b10);
    repeat (19) tick();
    chk("b_no_budget", {b_crn, b_done}, 2'b10);
    chk("b_count", b_cnt, 19);
    b_halt = 1'b1;
    tick();
    b_halt = 1'b0;
    chk("b_halt_done", {b_done, b_tmo}, 2'b10);
    chk("b_halt_count", b_cnt, 20);

    repeat (3) tick();
    chk("all_words_written", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
